// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the P7 pipeline hazard controller.
// Covers Tuse/Tnew values, the exception entry PC, MDU latencies and MDU FSM states.
package pipe_hazard_ctrl_pkg;

  // Tuse: cycles until the D instruction needs the operand (3 = operand unused)
  localparam logic [1:0] TUSE_0      = 2'd0;
  localparam logic [1:0] TUSE_1      = 2'd1;
  localparam logic [1:0] TUSE_2      = 2'd2;
  localparam logic [1:0] TUSE_UNUSED = 2'd3;

  // Tnew: cycles until the producer's result can be forwarded (never above 2)
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [31:0] EXC_ENTRY_PC = 32'h0000_4180;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic int max_cyc(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// MDU busy countdown: after a qualified start, busy stays high for exactly
// MULT_CYC or DIV_CYC cycles. A start while busy reloads the count.
module md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CW = $clog2(max_cyc(MULT_CYC, DIV_CYC) + 1);

  md_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (start) begin
      state_next = MD_BUSY;
      cnt_next   = is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else begin
      case (state_reg)
        MD_IDLE: begin
          cnt_next = '0;
        end
        MD_BUSY: begin
          cnt_next = cnt_reg - CW'(1);
          // Leave BUSY on the edge that takes the count from 1 to 0
          if (cnt_reg <= CW'(1)) begin
            state_next = MD_IDLE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = MD_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign busy = (state_reg == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: Tuse/Tnew and MDU stall detection, exception flush
// priority, MDU busy tracking and a stall-cycle performance counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_rs_tuse,
  input  logic [1:0]       D_rt_tuse,
  input  logic             D_is_md,
  input  logic [4:0]       E_A3,
  input  logic [1:0]       E_tnew,
  input  logic [4:0]       M_A3,
  input  logic [1:0]       M_tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  input  logic             cp0_req,
  output logic             PC_WE,
  output logic             FD_WE,
  output logic             DE_flush,
  output logic             req,
  output logic             md_busy,
  output logic             md_start_q,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0] d_src  [2];
  logic [1:0] d_tuse [2];
  logic [1:0] src_haz;
  logic       md_haz;
  logic       raw_stall;
  logic       stall;

  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  assign d_src[0]  = D_rs;
  assign d_src[1]  = D_rt;
  assign d_tuse[0] = D_rs_tuse;
  assign d_tuse[1] = D_rt_tuse;

  // $0 is hardwired, so it can never be a real dependency
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_haz
      assign src_haz[gi] = (d_src[gi] != 5'd0) &&
                           (((d_src[gi] == E_A3) && (E_tnew > d_tuse[gi])) ||
                            ((d_src[gi] == M_A3) && (M_tnew > d_tuse[gi])));
    end
  endgenerate

  // A start flushed out of E by an exception must not reach the MDU
  assign md_start_q = E_md_start & ~cp0_req;
  assign md_haz     = D_is_md & (md_busy | md_start_q);
  assign raw_stall  = |src_haz | md_haz;

  assign req      = cp0_req;
  assign stall    = raw_stall & ~cp0_req;
  assign PC_WE    = ~stall;
  assign FD_WE    = ~stall;
  assign DE_flush = stall;

  md_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_q),
    .is_div (E_md_div),
    .busy   (md_busy)
  );

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, MDU countdown, exception
// priority and reset during a divide, with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_div, cp0_req;
  logic        PC_WE, FD_WE, DE_flush, req, md_busy, md_start_q;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_rs_tuse  (D_rs_tuse),
    .D_rt_tuse  (D_rt_tuse),
    .D_is_md    (D_is_md),
    .E_A3       (E_A3),
    .E_tnew     (E_tnew),
    .M_A3       (M_A3),
    .M_tnew     (M_tnew),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .cp0_req    (cp0_req),
    .PC_WE      (PC_WE),
    .FD_WE      (FD_WE),
    .DE_flush   (DE_flush),
    .req        (req),
    .md_busy    (md_busy),
    .md_start_q (md_start_q),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Check the stall-related outputs together and print one line per check
  task automatic chk_stall(input string tag, input logic s);
    chk({tag, ".PC_WE"}, {31'd0, PC_WE}, {31'd0, ~s});
    chk({tag, ".FD_WE"}, {31'd0, FD_WE}, {31'd0, ~s});
    chk({tag, ".DE_flush"}, {31'd0, DE_flush}, {31'd0, s});
    $display("step %s: stall_exp=%0b PC_WE=%0b DE_flush=%0b md_busy=%0b stall_cnt=%0d",
             tag, s, PC_WE, DE_flush, md_busy, stall_cnt);
  endtask

  // Advance one clock; exp_stall is the stall expected in the cycle just ended
  task automatic tick(input logic exp_stall);
    @(posedge clk);
    if (exp_stall) exp_cnt++;
    #2;
  endtask

  task automatic idle_inputs();
    D_rs = 0; D_rt = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_is_md = 0;
    E_A3 = 0; E_tnew = 0; M_A3 = 0; M_tnew = 0;
    E_md_start = 0; E_md_div = 0; cp0_req = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst.md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk_stall("rst", 1'b0);

    // Load-use on rs: lw $5 in E, add using $5 at Tuse 1
    E_A3 = 5; E_tnew = 2; D_rs = 5; D_rs_tuse = 1; #1;
    chk_stall("loaduse.E", 1'b1);
    chk("loaduse.req", {31'd0, req}, 32'd0);
    tick(1'b1);
    E_A3 = 0; E_tnew = 0; M_A3 = 5; M_tnew = 1; #1;
    chk_stall("loaduse.M", 1'b0);
    chk("loaduse.cnt", {16'd0, stall_cnt}, 32'd1);

    // rt hazard through M, then same producer with enough Tuse slack
    idle_inputs();
    M_A3 = 7; M_tnew = 2; D_rt = 7; D_rt_tuse = 1; #1;
    chk_stall("rtM.haz", 1'b1);
    D_rt_tuse = 2; #1;
    chk_stall("rtM.slack", 1'b0);
    D_rt_tuse = 1;
    tick(1'b1);
    chk("rtM.cnt", {16'd0, stall_cnt}, 32'd2);

    // $0 never stalls; Tuse 3 never stalls
    idle_inputs();
    E_A3 = 0; E_tnew = 2; D_rs = 0; D_rs_tuse = 0; D_rt = 0; D_rt_tuse = 0; #1;
    chk_stall("zero", 1'b0);
    E_A3 = 5; D_rs = 5; D_rs_tuse = 3; D_rt_tuse = 3; #1;
    chk_stall("tuse3", 1'b0);
    tick(1'b0);

    // mult in E, mfhi in D: 6 stall cycles, released on cycle 7
    idle_inputs();
    E_md_start = 1; E_md_div = 0; D_is_md = 1; #1;
    chk("mult.start_q", {31'd0, md_start_q}, 32'd1);
    chk("mult.busy0", {31'd0, md_busy}, 32'd0);
    chk_stall("mult.c1", 1'b1);
    tick(1'b1);
    E_md_start = 0; E_md_div = 0; #1;
    for (int i = 2; i <= 6; i++) begin
      chk($sformatf("mult.busy%0d", i), {31'd0, md_busy}, 32'd1);
      chk_stall($sformatf("mult.c%0d", i), 1'b1);
      tick(1'b1);
    end
    chk("mult.busy_end", {31'd0, md_busy}, 32'd0);
    chk_stall("mult.c7", 1'b0);
    chk("mult.cnt", {16'd0, stall_cnt}, exp_cnt);
    D_is_md = 0;
    tick(1'b0);

    // div: busy 10 cycles, mfhi held in D throughout
    E_md_start = 1; E_md_div = 1; D_is_md = 1; #1;
    chk_stall("div.c1", 1'b1);
    tick(1'b1);
    E_md_start = 0; E_md_div = 0; #1;
    for (int i = 2; i <= 11; i++) begin
      chk($sformatf("div.busy%0d", i), {31'd0, md_busy}, 32'd1);
      chk_stall($sformatf("div.c%0d", i), 1'b1);
      tick(1'b1);
    end
    chk("div.busy_end", {31'd0, md_busy}, 32'd0);
    chk_stall("div.c12", 1'b0);
    chk("div.cnt", {16'd0, stall_cnt}, exp_cnt);
    D_is_md = 0;
    tick(1'b0);

    // Exception dominates load-use and suppresses the MDU start
    E_A3 = 5; E_tnew = 2; D_rs = 5; D_rs_tuse = 1; E_md_start = 1; cp0_req = 1; #1;
    chk("cp0.req", {31'd0, req}, 32'd1);
    chk("cp0.start_q", {31'd0, md_start_q}, 32'd0);
    chk_stall("cp0", 1'b0);
    tick(1'b0);
    idle_inputs(); #1;
    chk("cp0.busy", {31'd0, md_busy}, 32'd0);
    chk("cp0.cnt", {16'd0, stall_cnt}, exp_cnt);

    // Exception during BUSY neither stalls an MDU op nor aborts the countdown
    E_md_start = 1; #1;
    chk_stall("mulexc.start", 1'b0);
    tick(1'b0);
    E_md_start = 0; D_is_md = 1; cp0_req = 1; #1;
    chk("mulexc.busy1", {31'd0, md_busy}, 32'd1);
    chk_stall("mulexc.c1", 1'b0);
    tick(1'b0);
    cp0_req = 0; D_is_md = 0; #1;
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("mulexc.busy%0d", i), {31'd0, md_busy}, 32'd1);
      tick(1'b0);
    end
    chk("mulexc.busy_end", {31'd0, md_busy}, 32'd0);

    // Reset on the 3rd busy cycle of a div
    E_md_start = 1; E_md_div = 1; #1;
    tick(1'b0);
    E_md_start = 0; E_md_div = 0; D_is_md = 1; #1;
    chk_stall("rstdiv.b1", 1'b1);
    tick(1'b1);
    chk("rstdiv.b2", {31'd0, md_busy}, 32'd1);
    tick(1'b1);
    chk("rstdiv.b3", {31'd0, md_busy}, 32'd1);
    D_is_md = 0; reset = 1; #1;
    tick(1'b0);
    exp_cnt = 0;
    reset = 0; #1;
    chk("rstdiv.busy", {31'd0, md_busy}, 32'd0);
    chk("rstdiv.cnt", {16'd0, stall_cnt}, 32'd0);

    // Fresh mult after reset runs its full 5 cycles
    E_md_start = 1; E_md_div = 0; #1;
    tick(1'b0);
    E_md_start = 0; #1;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("postrst.busy%0d", i), {31'd0, md_busy}, 32'd1);
      tick(1'b0);
    end
    chk("postrst.busy_end", {31'd0, md_busy}, 32'd0);
    chk("postrst.cnt", {16'd0, stall_cnt}, exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
